// File: rtl/demux_sc_pkg.sv
// Shared constants and lane mapping for the 1:8 demultiplexing deserializer.
// Both the lane counter and the top level import this package.
package demux_sc_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  // Bit position within the word that counter value sel addresses.
  function automatic logic [SEL_W-1:0] lane_map(input logic [SEL_W-1:0] sel,
                                                input logic            lsb_first);
    logic [SEL_W-1:0] lane;
    if (lsb_first) begin
      lane = sel;
    end else begin
      lane = 3'd7 - sel;
    end
    return lane;
  endfunction

endpackage

// File: rtl/demux18_lane_ctr.sv
// Lane select counter for demux18_deser: tracks which lane the next serial bit
// belongs to, honouring word alignment and one-bit slips.
module demux18_lane_ctr
  import demux_sc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dv,
  input  logic             align,
  input  logic             slip,
  output logic [SEL_W-1:0] sel,
  output logic             cap_en,
  output logic [SEL_W-1:0] cap_sel
);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             pend_q, pend_d;

  // Next counter state and capture decision; ALIGN overrides slips and the count.
  always_comb begin
    sel_d   = sel_q;
    pend_d  = pend_q;
    cap_en  = 1'b0;
    cap_sel = sel_q;
    if (align) begin
      pend_d  = 1'b0;
      cap_sel = 3'd0;
      cap_en  = dv;
      sel_d   = dv ? 3'd1 : 3'd0;
    end else if (slip) begin
      // A valid bit arriving with the slip is the one discarded.
      pend_d = ~dv;
    end else if (pend_q) begin
      pend_d = ~dv;
    end else begin
      cap_en = dv;
      sel_d  = dv ? (sel_q + 3'd1) : sel_q;
    end
  end

  // Counter and slip-pending state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 3'd0;
      pend_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      pend_q <= pend_d;
    end
  end

  assign sel = sel_q;

endmodule

// File: rtl/demux18_deser.sv
// 1:8 demultiplexing deserializer: routes each serial bit to its lane, presents
// the assembled word through a valid/ready holding register with sticky overrun.
module demux18_deser
  import demux_sc_pkg::*;
#(
  parameter logic LSB_FIRST = 1'b1,
  parameter int   LANES     = 8
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       D,
  input  logic       DV,
  input  logic       ALIGN,
  input  logic       SLIP,
  input  logic       QRDY,
  input  logic       OVR_CLR,
  output logic [7:0] Q,
  output logic       QV,
  output logic [2:0] SEL,
  output logic       OVR
);

  generate
    if (LANES != 8) begin : g_lanes_check
      $error("demux18_deser: LANES must be 8");
    end
  endgenerate

  logic             cap_en_s;
  logic [SEL_W-1:0] cap_sel_s;
  logic [SEL_W-1:0] lane_s;
  logic [7:0]       word_s;
  logic             done_s;

  logic [7:0] acc_q, acc_d;
  logic [7:0] q_q, q_d;
  logic       qv_q, qv_d;
  logic       ovr_q, ovr_d;

  demux18_lane_ctr u_ctr (
    .clk     (CLK),
    .rst_n   (RSTN),
    .dv      (DV),
    .align   (ALIGN),
    .slip    (SLIP),
    .sel     (SEL),
    .cap_en  (cap_en_s),
    .cap_sel (cap_sel_s)
  );

  // Bit merge, word completion, output handshake and overrun tracking.
  always_comb begin
    lane_s = lane_map(cap_sel_s, LSB_FIRST);
    q_d    = q_q;
    qv_d   = qv_q;
    ovr_d  = ovr_q;
    if (ALIGN) begin
      word_s = 8'h00;
    end else begin
      word_s = acc_q;
    end
    if (cap_en_s) begin
      word_s[lane_s] = D;
    end else begin
      word_s = word_s;
    end
    done_s = cap_en_s & (cap_sel_s == 3'd7);
    acc_d  = done_s ? 8'h00 : word_s;
    if (done_s) begin
      if (qv_q && !QRDY) begin
        ovr_d = 1'b1;
      end else begin
        q_d  = word_s;
        qv_d = 1'b1;
      end
    end else begin
      // Written as a mask so an unknown QRDY propagates to QV in simulation.
      qv_d = qv_q & ~QRDY;
    end
    if (done_s && qv_q && !QRDY) begin
      ovr_d = 1'b1;
    end else if (OVR_CLR) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Accumulator, holding register and overrun flag.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      acc_q <= 8'h00;
      q_q   <= 8'h00;
      qv_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      q_q   <= q_d;
      qv_q  <= qv_d;
      ovr_q <= ovr_d;
    end
  end

  assign Q   = q_q;
  assign QV  = qv_q;
  assign OVR = ovr_q;

endmodule

// File: tb/tb_demux18_deser.sv
// Directed self-checking bench for demux18_deser (LSB-first and MSB-first instances).
module tb_demux18_deser;

  logic       clk;
  logic       rstn;
  logic       d, dv, align, slip, qrdy, ovr_clr;
  logic [7:0] q, q_m;
  logic       qv, qv_m, ovr, ovr_m;
  logic [2:0] sel, sel_m;

  int n_checks = 0;
  int n_fail   = 0;

  demux18_deser #(.LSB_FIRST(1'b1), .LANES(8)) dut (
    .CLK(clk), .RSTN(rstn), .D(d), .DV(dv), .ALIGN(align), .SLIP(slip),
    .QRDY(qrdy), .OVR_CLR(ovr_clr), .Q(q), .QV(qv), .SEL(sel), .OVR(ovr)
  );

  demux18_deser #(.LSB_FIRST(1'b0), .LANES(8)) dut_msb (
    .CLK(clk), .RSTN(rstn), .D(d), .DV(dv), .ALIGN(align), .SLIP(slip),
    .QRDY(qrdy), .OVR_CLR(ovr_clr), .Q(q_m), .QV(qv_m), .SEL(sel_m), .OVR(ovr_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic al);
    d = b; dv = 1'b1; align = al;
    tick();
    align = 1'b0; dv = 1'b0;
  endtask

  task automatic idle();
    d = 1'b0; dv = 1'b0; align = 1'b0; slip = 1'b0; ovr_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; d = 1'b0; dv = 1'b0; align = 1'b0; slip = 1'b0;
    qrdy = 1'b1; ovr_clr = 1'b0;
    tick(); tick();
    n_checks++;
    if (q !== 8'h00 || qv !== 1'b0 || sel !== 3'd0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got q=%h qv=%b sel=%0d ovr=%b, want 00/0/0/0", q, qv, sel, ovr);
    end
    rstn = 1'b1;
    tick();
  endtask

  // Bits 1,0,1,1,0,0,1,0: LSB-first gives 8'h4D, MSB-first gives 8'hB2.
  task automatic test_word_order();
    logic [7:0] bits;
    bits = 8'b0100_1101;
    qrdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[i], (i == 0));
      if (i == 6) begin
        n_checks++;
        if (qv !== 1'b0 || sel !== 3'd7) begin
          n_fail++;
          $display("FAIL order_pre_done: got qv=%b sel=%0d, want 0/7", qv, sel);
        end
      end
    end
    n_checks++;
    if (q !== 8'h4D || qv !== 1'b1 || sel !== 3'd0) begin
      n_fail++;
      $display("FAIL lsb_word: got q=%h qv=%b sel=%0d, want 4d/1/0", q, qv, sel);
    end
    n_checks++;
    if (q_m !== 8'hB2 || qv_m !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_word: got q=%h qv=%b, want b2/1", q_m, qv_m);
    end
    idle();
    n_checks++;
    if (qv !== 1'b0 || q !== 8'h4D) begin
      n_fail++;
      $display("FAIL qv_one_cycle: got qv=%b q=%h, want 0/4d", qv, q);
    end
  endtask

  // Two words with the consumer stalled: first is held, second overruns.
  task automatic test_back_to_back();
    logic [15:0] bits;
    bits = 16'h3C4D;
    qrdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_bit(bits[i], (i == 0));
      if (i == 7) begin
        n_checks++;
        if (q !== 8'h4D || qv !== 1'b1 || ovr !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_first: got q=%h qv=%b ovr=%b, want 4d/1/0", q, qv, ovr);
        end
      end
    end
    n_checks++;
    if (q !== 8'h4D || qv !== 1'b1 || ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_overrun: got q=%h qv=%b ovr=%b, want 4d/1/1", q, qv, ovr);
    end
    n_checks++;
    if (q_m !== 8'hB2 || ovr_m !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_msb_hold: got q=%h ovr=%b, want b2/1", q_m, ovr_m);
    end
    qrdy = 1'b1;
    idle();
    n_checks++;
    if (qv !== 1'b0 || ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_consume: got qv=%b ovr=%b, want 0/1", qv, ovr);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_checks++;
    if (ovr !== 1'b0 || qv !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: got ovr=%b qv=%b, want 0/0", ovr, qv);
    end
  endtask

  // Slip then a junk bit followed by the bits of 8'hA5 (LSB first).
  task automatic test_slip();
    logic [7:0] bits;
    bits = 8'hA5;
    qrdy = 1'b1;
    slip = 1'b1;
    tick();
    slip = 1'b1;
    tick();
    slip = 1'b0;
    send_bit(1'b1, 1'b0);
    n_checks++;
    if (sel !== 3'd0) begin
      n_fail++;
      $display("FAIL slip_hold_sel: got sel=%0d, want 0", sel);
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[i], 1'b0);
    end
    n_checks++;
    if (q !== 8'hA5 || qv !== 1'b1 || sel !== 3'd0) begin
      n_fail++;
      $display("FAIL slip_word: got q=%h qv=%b sel=%0d, want a5/1/0", q, qv, sel);
    end
    idle();
  endtask

  // ALIGN at SEL=5 discards ones already captured; the realigned word is 8'h96.
  task automatic test_align_midword();
    logic [7:0] bits;
    bits = 8'h96;
    qrdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, 1'b0);
    end
    n_checks++;
    if (sel !== 3'd5) begin
      n_fail++;
      $display("FAIL align_pre_sel: got sel=%0d, want 5", sel);
    end
    send_bit(bits[0], 1'b1);
    n_checks++;
    if (sel !== 3'd1) begin
      n_fail++;
      $display("FAIL align_sel: got sel=%0d, want 1", sel);
    end
    for (int i = 1; i < 8; i++) begin
      send_bit(bits[i], 1'b0);
    end
    n_checks++;
    if (q !== 8'h96 || qv !== 1'b1 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL align_word: got q=%h qv=%b ovr=%b, want 96/1/0", q, qv, ovr);
    end
  endtask

  // Reset asserted between edges at SEL=4 with a held word.
  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, (i == 0));
    end
    n_checks++;
    if (sel !== 3'd4 || qv !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got sel=%0d qv=%b, want 4/1", sel, qv);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (q !== 8'h00 || qv !== 1'b0 || sel !== 3'd0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got q=%h qv=%b sel=%0d ovr=%b, want 00/0/0/0", q, qv, sel, ovr);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_word_order();
    test_back_to_back();
    test_slip();
    test_align_midword();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
